// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and constants for the keypad event controller.
//   keypad_state_e : debounce / hold FSM state encoding
//   key_code_t     : 4-bit decoded key code
//   DEF_*          : default parameter values for keypad_event_ctrl
//   deb_inc/rpt_inc: saturating increments for the debounce and repeat timers
// -----------------------------------------------------------------------------
package keypad_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2,
      ST_RELEASE  = 2'd3
   } keypad_state_e;

   typedef logic [3:0] key_code_t;

   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_FIFO_DEPTH      = 4;
   localparam int DEF_REPEAT_DELAY    = 4096;
   localparam int DEF_REPEAT_PERIOD   = 1024;

   // Debounce counter covers DEBOUNCE_CYCLES up to 255; repeat timer covers
   // REPEAT_DELAY / REPEAT_PERIOD up to 2^20; occupancy covers depth 16.
   localparam int DEB_CNT_W = 8;
   localparam int RPT_CNT_W = 20;
   localparam int COUNT_W   = 5;

   function automatic logic [DEB_CNT_W-1:0] deb_inc(input logic [DEB_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic [RPT_CNT_W-1:0] rpt_inc(input logic [RPT_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/keypad_event_ctrl_if.sv
// -----------------------------------------------------------------------------
// keypad_event_ctrl_if
// Key-event stream between the keypad controller (master) and its consumer
// (slave).
//   key_code  : head-of-buffer key code        (master -> slave)
//   key_valid : buffer holds at least one event (master -> slave)
//   key_ready : consumer accepts the head       (slave -> master)
//
// Handshake: an event transfers on a rising clock edge where key_valid and
// key_ready are both high. key_valid never depends on key_ready, and key_code
// holds its value while key_valid=1 and key_ready=0. key_ready with
// key_valid=0 has no effect.
// -----------------------------------------------------------------------------
interface keypad_event_ctrl_if import keypad_pkg::*; ();

   key_code_t key_code;
   logic      key_valid;
   logic      key_ready;

   modport master (
      output key_code,
      output key_valid,
      input  key_ready
   );

   modport slave (
      input  key_code,
      input  key_valid,
      output key_ready
   );

endinterface

// File: rtl/keypad_fifo.sv
// -----------------------------------------------------------------------------
// keypad_fifo
// Small synchronous FIFO of 4-bit key codes.
//   clock, reset : clock, asynchronous active-high reset
//   push, data   : write request and code to store
//   pop          : read request (head advances)
//   head         : code at the read pointer
//   full, empty  : occupancy flags
//   count        : occupancy 0..DEPTH
// A push on a full FIFO is dropped unless a pop happens in the same cycle, in
// which case both complete and the count is unchanged. A pop on an empty FIFO
// is ignored. DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module keypad_fifo import keypad_pkg::*; #(
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               push,
   input  key_code_t          data,
   input  logic               pop,
   output key_code_t          head,
   output logic               full,
   output logic               empty,
   output logic [COUNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   key_code_t          mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [COUNT_W-1:0] count_q;
   logic               do_push;
   logic               do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == COUNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   // When full, the slot being written is the one being popped this cycle.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign count = count_q;

endmodule

// File: rtl/keypad_event_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_event_ctrl
// Debounces key presses reported by an external row/column scanner and queues
// one key event per accepted press in a small FIFO.
//
// Ports
//   clock, reset : sole clock, asynchronous active-high reset
//   row_raw      : asynchronous keypad row lines
//   row_sync     : synchronized row lines (to scanner Row input)
//   s_row        : OR of row_sync (to scanner S_Row input)
//   scan_code    : scanner decoded key code
//   scan_valid   : scanner single-cycle code-valid strobe
//   key          : key-event stream (keypad_event_ctrl_if.master)
//   fifo_count   : FIFO occupancy 0..FIFO_DEPTH
//   overflow     : sticky, set when an event is dropped on a full FIFO
//   dbg_state    : current FSM state
//
// Build option
//   KEYPAD_TYPEMATIC_EN : when defined, a held key re-pushes its code
//   REPEAT_DELAY cycles after acceptance and then every REPEAT_PERIOD cycles.
//   When undefined each accepted press pushes exactly once.
//
// Timing: the accept decision is registered (push_q) and the FIFO writes on
// the following edge, so key_valid rises DEBOUNCE_CYCLES+2 cycles after the
// scan_valid pulse for a cleanly held key.
// -----------------------------------------------------------------------------
module keypad_event_ctrl import keypad_pkg::*; #(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [3:0]                 row_raw,
   output logic [3:0]                 row_sync,
   output logic                       s_row,
   input  key_code_t                  scan_code,
   input  logic                       scan_valid,
   keypad_event_ctrl_if.master        key,
   output logic [COUNT_W-1:0]         fifo_count,
   output logic                       overflow,
   output keypad_state_e              dbg_state
);

`ifdef KEYPAD_TYPEMATIC_EN
   localparam bit TYPEMATIC_EN = 1'b1;
`else
   localparam bit TYPEMATIC_EN = 1'b0;
`endif

   localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);
   // Entering RELEASE already consumed one low cycle (the one seen in HELD),
   // so RELEASE needs DEBOUNCE_CYCLES-1 more for a full low run.
   localparam logic [DEB_CNT_W-1:0] REL_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 2);
   localparam logic [RPT_CNT_W-1:0] RPT_FIRST_LAST = RPT_CNT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_CNT_W-1:0] RPT_NEXT_LAST  = RPT_CNT_W'(REPEAT_PERIOD - 1);

   // Row synchronizer
   logic [3:0] row_meta;
   logic [3:0] row_sync_q;
   logic       row_active;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         row_meta   <= '0;
         row_sync_q <= '0;
      end else begin
         row_meta   <= row_raw;
         row_sync_q <= row_meta;
      end
   end

   assign row_sync   = row_sync_q;
   assign s_row      = |row_sync_q;
   assign row_active = |row_sync_q;

   // FSM state and datapath registers
   keypad_state_e          state_q,        state_d;
   logic [DEB_CNT_W-1:0]   deb_cnt_q,      deb_cnt_d;
   key_code_t              code_q,         code_d;
   logic                   push_q,         push_d;
   logic [RPT_CNT_W-1:0]   rpt_cnt_q,      rpt_cnt_d;
   logic                   rpt_periodic_q, rpt_periodic_d;
   logic [RPT_CNT_W-1:0]   rpt_last;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         deb_cnt_q      <= '0;
         code_q         <= '0;
         push_q         <= 1'b0;
         rpt_cnt_q      <= '0;
         rpt_periodic_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         deb_cnt_q      <= deb_cnt_d;
         code_q         <= code_d;
         push_q         <= push_d;
         rpt_cnt_q      <= rpt_cnt_d;
         rpt_periodic_q <= rpt_periodic_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      deb_cnt_d      = deb_cnt_q;
      code_d         = code_q;
      push_d         = 1'b0;
      rpt_cnt_d      = rpt_cnt_q;
      rpt_periodic_d = rpt_periodic_q;
      rpt_last       = rpt_periodic_q ? RPT_NEXT_LAST : RPT_FIRST_LAST;

      case (state_q)
         ST_IDLE: begin
            rpt_cnt_d      = '0;
            rpt_periodic_d = 1'b0;
            if (scan_valid) begin
               code_d    = scan_code;
               deb_cnt_d = '0;
               state_d   = ST_DEBOUNCE;
            end
         end

         ST_DEBOUNCE: begin
            if (!row_active) begin
               state_d = ST_IDLE;
            end else if (deb_cnt_q == DEB_LAST) begin
               push_d         = 1'b1;
               state_d        = ST_HELD;
               rpt_cnt_d      = '0;
               rpt_periodic_d = 1'b0;
            end else begin
               deb_cnt_d = deb_inc(deb_cnt_q);
            end
         end

         ST_HELD: begin
            // scan_valid is deliberately ignored while a key is held.
            if (!row_active) begin
               deb_cnt_d = '0;
               state_d   = ST_RELEASE;
            end else if (TYPEMATIC_EN) begin
               if (rpt_cnt_q == rpt_last) begin
                  push_d         = 1'b1;
                  rpt_cnt_d      = '0;
                  rpt_periodic_d = 1'b1;
               end else begin
                  rpt_cnt_d = rpt_inc(rpt_cnt_q);
               end
            end
         end

         ST_RELEASE: begin
            // Repeat timer is left untouched here so it pauses across a glitch.
            if (row_active) begin
               deb_cnt_d = '0;
               state_d   = ST_HELD;
            end else if (deb_cnt_q >= REL_LAST) begin
               state_d = ST_IDLE;
            end else begin
               deb_cnt_d = deb_inc(deb_cnt_q);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign dbg_state = state_q;

   // Event buffer
   logic      fifo_full;
   logic      fifo_empty;
   key_code_t fifo_head;

   keypad_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push_q),
      .data  (code_q),
      .pop   (key.key_ready),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign key.key_code  = fifo_head;
   assign key.key_valid = !fifo_empty;

   // Full implies non-empty, so key_ready alone means a pop makes room.
   logic overflow_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         overflow_q <= 1'b0;
      end else if (push_q && fifo_full && !key.key_ready) begin
         overflow_q <= 1'b1;
      end
   end

   assign overflow = overflow_q;

endmodule

// File: tb/tb_keypad_event_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keypad_event_ctrl
// Directed bench for keypad_event_ctrl with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4,
// REPEAT_DELAY=32, REPEAT_PERIOD=8. Inputs change 1 time unit after a rising
// edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_keypad_event_ctrl;
   import keypad_pkg::*;

   // Clock / reset
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic [3:0]    row_raw;
   logic [3:0]    row_sync;
   logic          s_row;
   key_code_t     scan_code;
   logic          scan_valid;
   logic [4:0]    fifo_count;
   logic          overflow;
   keypad_state_e dbg_state;

   keypad_event_ctrl_if key_if();

   keypad_event_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .FIFO_DEPTH      (4),
      .REPEAT_DELAY    (32),
      .REPEAT_PERIOD   (8)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .row_raw    (row_raw),
      .row_sync   (row_sync),
      .s_row      (s_row),
      .scan_code  (scan_code),
      .scan_valid (scan_valid),
      .key        (key_if),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .dbg_state  (dbg_state)
   );

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   logic [31:0] exp_q[$];
   logic [31:0] obs_q[$];

   // Driver tasks
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic scan_pulse(input logic [3:0] code);
      scan_code  = code;
      scan_valid = 1'b1;
      tick();
      scan_valid = 1'b0;
   endtask

   // Full press/release cycle; the event lands in the FIFO and is not popped.
   task automatic press(input logic [3:0] code);
      row_raw = 4'b0001;
      repeat (3) tick();
      scan_pulse(code);
      repeat (6) tick();
      row_raw = 4'b0000;
      repeat (10) tick();
   endtask

   task automatic pop_one();
      key_if.key_ready = 1'b1;
      tick();
      key_if.key_ready = 1'b0;
   endtask

   initial begin
      reset            = 1'b1;
      row_raw          = 4'b0000;
      scan_code        = 4'h0;
      scan_valid       = 1'b0;
      key_if.key_ready = 1'b0;

      // Reset state
      repeat (2) tick();
      check("rst_key_valid",  key_if.key_valid, 0);
      check("rst_key_code",   key_if.key_code,  0);
      check("rst_fifo_count", fifo_count,       0);
      check("rst_overflow",   overflow,         0);
      check("rst_row_sync",   row_sync,         0);
      check("rst_s_row",      s_row,            0);
      check("rst_state",      dbg_state,        ST_IDLE);
      reset = 1'b0;
      tick();

      // Clean press: key_valid rises 6 cycles after the scan pulse
      row_raw = 4'b0100;
      tick();
      tick();
      check("sync_row", row_sync, 4'b0100);
      check("sync_s_row", s_row, 1);
      scan_pulse(4'hA);
      repeat (4) tick();
      check("clean_not_early", key_if.key_valid, 0);
      tick();
      check("clean_valid", key_if.key_valid, 1);
      check("clean_code", key_if.key_code, 4'hA);
      check("clean_count", fifo_count, 1);
      check("clean_state_held", dbg_state, ST_HELD);
      repeat (3) tick();
      check("clean_code_stable", key_if.key_code, 4'hA);
      check("clean_once", fifo_count, 1);
      pop_one();
      check("clean_popped", key_if.key_valid, 0);
      row_raw = 4'b0000;
      repeat (10) tick();
      check("clean_idle", dbg_state, ST_IDLE);
      check("clean_no_extra", fifo_count, 0);

      // Bounce: row drops for one cycle two cycles after the pulse
      row_raw = 4'b0100;
      repeat (3) tick();
      scan_pulse(4'h3);
      tick();
      row_raw = 4'b0000;
      tick();
      row_raw = 4'b0100;
      tick();
      check("bounce_row_low", row_sync, 4'b0000);
      tick();
      check("bounce_idle", dbg_state, ST_IDLE);
      repeat (6) tick();
      check("bounce_no_push", key_if.key_valid, 0);
      check("bounce_count", fifo_count, 0);
      check("bounce_stays_idle", dbg_state, ST_IDLE);
      row_raw = 4'b0000;
      repeat (4) tick();

      // Overflow: five presses into a depth-4 FIFO with no consumer
      for (int i = 1; i <= 4; i++) press(4'(i));
      check("ovf_full_count", fifo_count, 4);
      check("ovf_not_yet", overflow, 0);
      press(4'h5);
      check("ovf_count", fifo_count, 4);
      check("ovf_flag", overflow, 1);
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("ovf_pop%0d", i), key_if.key_code, i);
         pop_one();
      end
      check("ovf_empty", key_if.key_valid, 0);
      check("ovf_sticky", overflow, 1);
      pop_one();
      check("empty_pop_ignored", fifo_count, 0);

      // Full FIFO: push and pop in the same cycle
      do_reset();
      check("reset_clears_ovf", overflow, 0);
      for (int i = 1; i <= 4; i++) press(4'(i));
      check("fpp_full", fifo_count, 4);
      row_raw = 4'b0001;
      repeat (3) tick();
      scan_pulse(4'h5);
      repeat (4) tick();
      key_if.key_ready = 1'b1;
      tick();
      key_if.key_ready = 1'b0;
      check("fpp_count", fifo_count, 4);
      check("fpp_no_ovf", overflow, 0);
      row_raw = 4'b0000;
      repeat (10) tick();
      for (int i = 2; i <= 5; i++) begin
         check($sformatf("fpp_pop%0d", i), key_if.key_code, i);
         pop_one();
      end
      check("fpp_drained", fifo_count, 0);

      // Reset asserted asynchronously mid-DEBOUNCE with one event queued
      press(4'h9);
      check("rmd_pre_count", fifo_count, 1);
      row_raw = 4'b0100;
      repeat (3) tick();
      scan_pulse(4'h7);
      tick();
      check("rmd_in_debounce", dbg_state, ST_DEBOUNCE);
      #2;
      reset = 1'b1;
      #1;
      check("rmd_row_sync", row_sync, 0);
      check("rmd_s_row", s_row, 0);
      check("rmd_key_valid", key_if.key_valid, 0);
      check("rmd_key_code", key_if.key_code, 0);
      check("rmd_count", fifo_count, 0);
      check("rmd_overflow", overflow, 0);
      check("rmd_state", dbg_state, ST_IDLE);
      tick();
      tick();
      reset = 1'b0;
      repeat (12) tick();
      check("rmd_row_back", row_sync, 4'b0100);
      check("rmd_no_event", key_if.key_valid, 0);
      check("rmd_no_count", fifo_count, 0);
      check("rmd_idle", dbg_state, ST_IDLE);
      row_raw = 4'b0000;
      repeat (4) tick();

      // Long hold of code 0x5 with a consumer always ready
`ifdef KEYPAD_TYPEMATIC_EN
      exp_q = '{32'd5, 32'd37, 32'd45, 32'd53, 32'd61};
`else
      exp_q = '{32'd5};
`endif
      key_if.key_ready = 1'b1;
      row_raw = 4'b0010;
      repeat (3) tick();
      scan_pulse(4'h5);
      for (int i = 0; i < 66; i++) begin
         if (key_if.key_valid) begin
            obs_q.push_back(32'(i));
            check($sformatf("hold_code_at%0d", i), key_if.key_code, 4'h5);
         end
         tick();
      end
      row_raw = 4'b0000;
      key_if.key_ready = 1'b0;
      check("hold_event_count", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         check($sformatf("hold_event%0d_cycle", i),
               (i < obs_q.size()) ? obs_q[i] : 32'hFFFF_FFFF, exp_q[i]);
      end
      repeat (10) tick();
      check("hold_end_idle", dbg_state, ST_IDLE);

      // Final report
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/keypad_event_ctrl.md
KEYPAD_EVENT_CTRL -- requirements
Module: keypad_event_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, SHALL set the row-stable cycles required to accept a press or a release (legal range 2..255).
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the key-event buffer depth (power of two, 2..16).
REQ-003 Parameter REPEAT_DELAY, default 4096, SHALL set the cycles from accepted press to first auto-repeat.
REQ-004 Parameter REPEAT_PERIOD, default 1024, SHALL set the cycles between subsequent auto-repeats.
REQ-005 clock  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-007 row_raw  input  4  SHALL be the asynchronous keypad row lines, one-hot when a single key is pressed.
REQ-008 row_sync  output  4  SHALL be the synchronized row lines, driven to the scanner Row input.
REQ-009 s_row  output  1  SHALL be OR of row_sync, driven to the scanner S_Row input.
REQ-010 scan_code  input  4  SHALL be the scanner's decoded key code (0x0..0xF).
REQ-011 scan_valid  input  1  SHALL be the scanner's single-cycle code-valid strobe.
REQ-012 key_code  output  4  SHALL be the FIFO head code.
REQ-013 key_valid  output  1  SHALL be high whenever the FIFO is non-empty.
REQ-014 key_ready  input  1  SHALL pop the head when high in a cycle with key_valid high.
REQ-015 fifo_count  output  5  SHALL be the FIFO occupancy (0..FIFO_DEPTH).
REQ-016 overflow  output  1  SHALL be a sticky flag set when an event is dropped on a full FIFO.

Function
REQ-017 row_raw SHALL pass through a two-flop synchronizer; row_sync is the second flop.
REQ-018 The FSM SHALL have states IDLE, DEBOUNCE, HELD, RELEASE.
REQ-019 IDLE: on scan_valid=1, SHALL capture scan_code, clear the counter, and enter DEBOUNCE; otherwise remain.
REQ-020 DEBOUNCE: row_sync==0 SHALL return to IDLE with no push; otherwise increment; when the counter equals DEBOUNCE_CYCLES-1 with row_sync!=0, SHALL push the captured code and enter HELD.
REQ-021 HELD: row_sync==0 SHALL clear the counter and enter RELEASE; scan_valid in HELD SHALL be ignored.
REQ-022 RELEASE: row_sync!=0 SHALL return to HELD (counter cleared); row_sync==0 for DEBOUNCE_CYCLES consecutive cycles SHALL enter IDLE.
REQ-023 Push-to-key_valid latency SHALL be one cycle; key_code SHALL be stable while key_valid=1 and key_ready=0.
REQ-024 Push on full FIFO without simultaneous pop SHALL drop the event and set overflow; push and pop in the same cycle when full SHALL both succeed, with count unchanged.
REQ-025 Pop on empty FIFO SHALL be ignored; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 Counters SHALL saturate and never wrap.

Reset
REQ-027 Reset SHALL clear synchronizer, FSM (IDLE), counters, FIFO pointers, and overflow; outputs: row_sync=0, s_row=0, key_valid=0, key_code=0, fifo_count=0, overflow=0.
REQ-028 Reset mid-press SHALL discard any captured, unpushed code; after reset release, a still-held key SHALL produce no event until the scanner strobes scan_valid again.

Configuration
REQ-029 Macro KEYPAD_TYPEMATIC_EN defined: in HELD, SHALL push the captured code again REPEAT_DELAY cycles after entry from DEBOUNCE, then every REPEAT_PERIOD cycles; the repeat timer SHALL pause in RELEASE and reset on entry to IDLE.
REQ-030 Macro undefined: exactly one push per accepted press; repeat logic and REPEAT_* parameters SHALL have no effect.

Structure
REQ-031 Package keypad_pkg SHALL hold the FSM state enum, the 4-bit key-code typedef, and default parameter constants.
REQ-032 The buffer SHALL be a sub-module keypad_fifo (parameterized depth, width 4, push/pop/full/empty/count).

Verification (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, REPEAT_DELAY=32, REPEAT_PERIOD=8)
REQ-033 Clean press: row_raw=4'b0100 held, scan_valid pulse with code 0xA -> key_valid=1 with key_code=0xA exactly once, 6 cycles after the pulse.
REQ-034 Bounce: row_raw returns to 0 for 1 cycle, 2 cycles after scan_valid -> no push; FSM returns to IDLE.
REQ-035 Overflow: 5 presses (codes 1,2,3,4,5), key_ready=0 -> fifo_count=4, overflow=1, pops yield 1,2,3,4.
REQ-036 Full push+pop: FIFO full, key_ready=1 in the push cycle -> count stays 4, overflow stays 0.
REQ-037 Reset mid-DEBOUNCE: assert reset asynchronously -> all outputs 0 immediately; no event after deassertion.
REQ-038 KEYPAD_TYPEMATIC_EN: hold code 0x5 for 60 cycles -> pushes at accept, +32, +40, +48, +56.
